// File: rtl/blink_seq_pkg.sv
// Shared definitions for the LED blink burst sequencer: state encoding and
// default sizing constants used by blink_sequencer and its prescaler.
package blink_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_OFF  = 2'b10
    } blink_state_t;

    localparam int DEF_WIDTH      = 22;
    localparam int DEF_NB         = 4;
    localparam int DEF_ON_CYCLES  = 2097152;
    localparam int DEF_OFF_CYCLES = 2097152;

endpackage

// File: rtl/blink_sequencer_tick.sv
// Prescaler for the blink sequencer: a WIDTH-bit up-counter with synchronous
// clear and count enable. tc is high while the count equals the supplied
// terminal value; the owner clears the counter at TC so it never wraps.
module tick_counter #(
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic             tc
);

    logic [WIDTH-1:0] count_r;

    // Prescaler register: reset and clear both force zero, otherwise count when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            count_r <= {WIDTH{1'b0}};
        end else if (en) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == term);

endmodule

// File: rtl/blink_sequencer.sv
// Timed LED blink burst controller. START launches N on/off pulses of
// ON_CYCLES / OFF_CYCLES clocks each, then DONE pulses for one cycle.
// ABORT cancels a burst in progress. All outputs are registered and are
// derived from the next state, so they line up with the state they describe.
// Optional feature: define BLINK_SEQ_REPEAT_EN to add a REPEAT input that
// restarts the burst (with the originally latched N) after each DONE.
module blink_sequencer
    import blink_seq_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter int OFF_CYCLES = DEF_OFF_CYCLES,
    parameter int NB         = DEF_NB
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          START,
    input  logic [NB-1:0] N,
    input  logic          ABORT,
`ifdef BLINK_SEQ_REPEAT_EN
    input  logic          REPEAT,
`endif
    output logic          LED,
    output logic          BUSY,
    output logic          DONE,
    output logic [NB-1:0] REMAIN
);

    // Terminal values: the prescaler runs 0..CYCLES-1 within each phase.
    localparam logic [WIDTH-1:0] ON_TERM  = WIDTH'(ON_CYCLES - 32'sd1);
    localparam logic [WIDTH-1:0] OFF_TERM = WIDTH'(OFF_CYCLES - 32'sd1);

    blink_state_t     state_r;
    blink_state_t     next_state_s;
    logic [NB-1:0]    remain_r;
    logic [NB-1:0]    remain_next_s;
    logic             done_next_s;
    logic             led_r;
    logic             busy_r;
    logic             done_r;
    logic             tick_clr_s;
    logic             tick_en_s;
    logic [WIDTH-1:0] tick_term_s;
    logic             tick_tc_s;
`ifdef BLINK_SEQ_REPEAT_EN
    logic [NB-1:0]    n_latched_r;
`endif

    tick_counter #(
        .WIDTH (WIDTH)
    ) u_tick (
        .clk   (CLK),
        .reset (RESET),
        .clr   (tick_clr_s),
        .en    (tick_en_s),
        .term  (tick_term_s),
        .tc    (tick_tc_s)
    );

    // Prescaler control: clear on every state entry, count while a phase runs.
    always_comb begin
        tick_clr_s = (next_state_s != state_r);
        tick_en_s  = (state_r != ST_IDLE);
        if (state_r == ST_ON) begin
            tick_term_s = ON_TERM;
        end else begin
            tick_term_s = OFF_TERM;
        end
    end

    // Next-state, blink-count and DONE decision for the burst sequence.
    always_comb begin
        next_state_s  = state_r;
        remain_next_s = remain_r;
        done_next_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // ABORT in IDLE only serves to block a simultaneous START.
                if (START && !ABORT) begin
                    if (N != {NB{1'b0}}) begin
                        next_state_s  = ST_ON;
                        remain_next_s = N;
                    end else begin
                        done_next_s = 1'b1;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ON: begin
                if (ABORT) begin
                    next_state_s  = ST_IDLE;
                    remain_next_s = {NB{1'b0}};
                end else if (tick_tc_s) begin
                    next_state_s = ST_OFF;
                    // A pulse counts as finished once its high phase ends.
                    if (remain_r != {NB{1'b0}}) begin
                        remain_next_s = remain_r - NB'(1'b1);
                    end else begin
                        remain_next_s = remain_r;
                    end
                end else begin
                    next_state_s = ST_ON;
                end
            end
            ST_OFF: begin
                if (ABORT) begin
                    next_state_s  = ST_IDLE;
                    remain_next_s = {NB{1'b0}};
                end else if (tick_tc_s) begin
                    if (remain_r == {NB{1'b0}}) begin
                        done_next_s = 1'b1;
`ifdef BLINK_SEQ_REPEAT_EN
                        if (REPEAT) begin
                            next_state_s  = ST_ON;
                            remain_next_s = n_latched_r;
                        end else begin
                            next_state_s = ST_IDLE;
                        end
`else
                        next_state_s = ST_IDLE;
`endif
                    end else begin
                        next_state_s = ST_ON;
                    end
                end else begin
                    next_state_s = ST_OFF;
                end
            end
            default: begin
                next_state_s  = ST_IDLE;
                remain_next_s = {NB{1'b0}};
            end
        endcase
    end

    // State, count and output registers; outputs reflect the state being entered.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r  <= ST_IDLE;
            remain_r <= {NB{1'b0}};
            led_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            remain_r <= remain_next_s;
            led_r    <= (next_state_s == ST_ON);
            busy_r   <= (next_state_s != ST_IDLE);
            done_r   <= done_next_s;
        end
    end

`ifdef BLINK_SEQ_REPEAT_EN
    // Remember the accepted blink count so a repeated burst can reload it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            n_latched_r <= {NB{1'b0}};
        end else if ((state_r == ST_IDLE) && START && !ABORT) begin
            n_latched_r <= N;
        end else begin
            n_latched_r <= n_latched_r;
        end
    end
`endif

    assign LED    = led_r;
    assign BUSY   = busy_r;
    assign DONE   = done_r;
    assign REMAIN = remain_r;

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed bench for blink_sequencer with ON_CYCLES=3, OFF_CYCLES=2, NB=4.
// Expected outputs for each upcoming cycle are queued from the burst timing
// rules and popped/compared one cycle after the matching input is applied.
module tb_blink_sequencer;

    localparam int ON_C  = 3;
    localparam int OFF_C = 2;
    localparam int PER   = ON_C + OFF_C;

    typedef struct packed {
        logic       led;
        logic       busy;
        logic       done;
        logic [3:0] remain;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic [3:0] N = 4'd0;
    logic       ABORT = 1'b0;
`ifdef BLINK_SEQ_REPEAT_EN
    logic       REPEAT = 1'b0;
`endif
    logic       LED;
    logic       BUSY;
    logic       DONE;
    logic [3:0] REMAIN;

    exp_t  exp_q[$];
    int    checks = 0;
    int    failures = 0;
    string phase = "init";

    blink_sequencer #(
        .WIDTH      (4),
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .NB         (4)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .N      (N),
        .ABORT  (ABORT),
`ifdef BLINK_SEQ_REPEAT_EN
        .REPEAT (REPEAT),
`endif
        .LED    (LED),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .REMAIN (REMAIN)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void push(input logic led, input logic busy,
                                 input logic done, input logic [3:0] rem);
        exp_t e;
        e.led = led;
        e.busy = busy;
        e.done = done;
        e.remain = rem;
        exp_q.push_back(e);
    endfunction

    function automatic void push_idle();
        push(1'b0, 1'b0, 1'b0, 4'd0);
    endfunction

    // Expected outputs for cycles first..last after START (cycle 0) of an n-blink burst.
    function automatic void push_body(input int n, input int first, input int last);
        for (int c = first; c <= last; c++) begin
            int blk;
            int k;
            int rem;
            blk = (c - 1) / PER;
            k = (c - 1) % PER;
            rem = n - blk - ((k >= ON_C) ? 1 : 0);
            push((k < ON_C), 1'b1, 1'b0, 4'(rem));
        end
    endfunction

    function automatic void push_burst(input int n);
        push_body(n, 1, n * PER);
        push(1'b0, 1'b0, 1'b1, 4'd0);
    endfunction

    task automatic cmp(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s.%s got=%0h exp=%0h", phase, name, got, want);
        end
    endtask

    task automatic check_cycle();
        exp_t e;
        checks++;
        assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL %s.queue got=%0d exp=nonempty", phase, exp_q.size());
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("led", {3'b000, LED}, {3'b000, e.led});
            cmp("busy", {3'b000, BUSY}, {3'b000, e.busy});
            cmp("done", {3'b000, DONE}, {3'b000, e.done});
            cmp("remain", REMAIN, e.remain);
        end
    endtask

    // Apply inputs for one cycle, clock it, then check the resulting outputs.
    task automatic cyc(input logic st, input logic [3:0] n, input logic ab, input logic rs);
        START = st;
        N = n;
        ABORT = ab;
        RESET = rs;
        @(posedge CLK);
        #1;
        check_cycle();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            cyc(1'b0, 4'd0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // Reset for two cycles with random other inputs.
        phase = "reset";
        push_idle();
        push_idle();
        cyc(1'($urandom), 4'($urandom), 1'($urandom), 1'b1);
        cyc(1'($urandom), 4'($urandom), 1'($urandom), 1'b1);
        push_idle();
        idle(1);

        // Two-blink burst.
        phase = "n2";
        push_burst(2);
        push_idle();
        cyc(1'b1, 4'd2, 1'b0, 1'b0);
        idle(11);

        // Zero blinks: immediate DONE, no LED activity.
        phase = "n0";
        push(1'b0, 1'b0, 1'b1, 4'd0);
        push_idle();
        cyc(1'b1, 4'd0, 1'b0, 1'b0);
        idle(1);

        // Abort in the last OFF cycle of the first pulse.
        phase = "abort";
        push_body(3, 1, 5);
        for (int i = 0; i < 12; i++) push_idle();
        cyc(1'b1, 4'd3, 1'b0, 1'b0);
        idle(4);
        cyc(1'b0, 4'd0, 1'b1, 1'b0);
        idle(11);

        // ABORT in IDLE blocks a simultaneous START.
        phase = "abort_idle";
        push_idle();
        push_idle();
        cyc(1'b1, 4'd2, 1'b1, 1'b0);
        idle(1);

        // START while busy is ignored; START in the DONE cycle is accepted.
        phase = "restart";
        push_burst(2);
        push_body(1, 1, PER);
        push(1'b0, 1'b0, 1'b1, 4'd0);
        push_idle();
        cyc(1'b1, 4'd2, 1'b0, 1'b0);
        idle(2);
        cyc(1'b1, 4'd5, 1'b0, 1'b0);
        idle(7);
        cyc(1'b1, 4'd1, 1'b0, 1'b0);
        idle(6);

        // Reset mid-ON, then reset overriding a START.
        phase = "reset_mid";
        push_body(2, 1, 2);
        push_idle();
        push_idle();
        push_idle();
        cyc(1'b1, 4'd2, 1'b0, 1'b0);
        idle(1);
        cyc(1'b0, 4'd0, 1'b0, 1'b1);
        cyc(1'b1, 4'd3, 1'b0, 1'b1);
        idle(1);

`ifdef BLINK_SEQ_REPEAT_EN
        // Repeat mode, N=1: DONE at cycles 6 and 11 with LED unbroken, then abort.
        phase = "repeat";
        push_body(1, 1, PER);
        push(1'b1, 1'b1, 1'b1, 4'd1);
        push(1'b1, 1'b1, 1'b0, 4'd1);
        push(1'b1, 1'b1, 1'b0, 4'd1);
        push(1'b0, 1'b1, 1'b0, 4'd0);
        push(1'b0, 1'b1, 1'b0, 4'd0);
        push(1'b1, 1'b1, 1'b1, 4'd1);
        push_idle();
        push_idle();
        REPEAT = 1'b1;
        cyc(1'b1, 4'd1, 1'b0, 1'b0);
        idle(10);
        cyc(1'b0, 4'd0, 1'b1, 1'b0);
        REPEAT = 1'b0;
        idle(1);
`endif

        phase = "drain";
        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL %s.leftover got=%0d exp=0", phase, exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
